// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: CPU widths, FSM encoding, request latch type.
// Latency: n/a. Backpressure: n/a.
package dmem_responder_pkg;

  localparam int DMEM_DW = 16;
  localparam int CPU_AW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [CPU_AW-1:0] addr;
  } req_t;

  // True when every address bit above the word index is zero.
  function automatic logic addr_in_range(input logic [CPU_AW-1:0] addr, input int aw);
    return (addr >> (aw + 1)) == '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2**AW x DW RAM with write enable and registered read, no reset.
// Latency: read data valid one edge after en. Backpressure: none, always accepts.
// A write and a read of the same word on one edge return the old contents.
module dmem_array #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) mem[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MEM-stage load/store port; optional bounds check under DMEM_BOUNDS_EN.
// Latency: accept edge -> one-cycle rsp_valid after WAIT_STATES+1 cycles.
// Backpressure: req_ready only in IDLE; mem_stall holds the pipeline from accept through WAIT.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DW          = DMEM_DW,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [CPU_AW-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              mem_stall
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              load_q, load_d;

  logic              acc_we;
  logic [CPU_AW-1:0] acc_addr;
  logic [DW-1:0]     acc_wdata;
  logic              commit;
  logic              in_range;
  logic              ram_we;
  logic [DW-1:0]     ram_rdata;
  logic              unused_addr_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we   = req_we;
          req_d.addr = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = 4'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the array access happens on the accept edge, so the
  // live request fields are used before they reach the latch.
  always_comb begin
    acc_we    = req_q.we;
    acc_addr  = req_q.addr;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    commit = (state_d == ST_RESP) && (state_q != ST_RESP) && !reset;
`ifdef DMEM_BOUNDS_EN
    in_range = addr_in_range(acc_addr, AW);
`else
    in_range = 1'b1;
`endif
    ram_we = commit && acc_we && in_range;
    load_d = commit ? (!acc_we && in_range) : load_q;
  end

  assign unused_addr_bits = ^acc_addr;

  dmem_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .en   (commit),
    .we   (ram_we),
    .addr (acc_addr[AW:1]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

`ifdef DMEM_BOUNDS_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (commit) err_d = !in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    mem_stall = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
    rsp_rdata = load_q ? ram_rdata : '0;
`ifdef DMEM_BOUNDS_EN
    rsp_err   = err_q && (state_q == ST_RESP);
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with 2 wait states, one with none, scoreboard on responses.
// Latency: n/a. Backpressure: n/a.
module tb_dmem_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;
`ifdef DMEM_BOUNDS_EN
  localparam logic BOUNDS = 1'b1;
`else
  localparam logic BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        mem_stall [2];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DW(16), .AW(8), .WAIT_STATES(WS0)) u_dut_w2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_stall(mem_stall[0])
  );

  dmem_responder #(.DW(16), .AW(8), .WAIT_STATES(WS1)) u_dut_w0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_stall(mem_stall[1])
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int d, input logic [15:0] rdata, input logic err, input int at);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = at;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_rsp(input int d);
    exp_t e;
    if (qsize(d) == 0) begin
      check_val($sformatf("unexpected_rsp_dut%0d", d), 32'(rsp_valid[d]), 0);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check_val($sformatf("rsp_rdata_dut%0d", d), 32'(rsp_rdata[d]), 32'(e.rdata));
      check_val($sformatf("rsp_err_dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
      check_val($sformatf("rsp_latency_dut%0d", d), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rsp_valid[d]) check_rsp(d);
  end

  task automatic send(input int d, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_rdata,
                      input logic exp_err, input bit expect_rsp);
    bit acc = 1'b0;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        acc = 1'b1;
        if (expect_rsp) push_exp(d, exp_rdata, exp_err, cyc + ws(d) + 1);
      end
    end
    check_val($sformatf("accept_dut%0d", d), 32'(acc), 1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (qsize(d) == 0) break;
    end
    check_val($sformatf("drain_dut%0d", d), 32'(qsize(d)), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst_ready_dut%0d", d), 32'(req_ready[d]), 1);
      check_val($sformatf("rst_valid_dut%0d", d), 32'(rsp_valid[d]), 0);
      check_val($sformatf("rst_rdata_dut%0d", d), 32'(rsp_rdata[d]), 0);
      check_val($sformatf("rst_stall_dut%0d", d), 32'(mem_stall[d]), 0);
    end

    // Store then load, two wait states
    send(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
    drain(0);
    send(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    drain(0);

    // Zero wait states, bit0 of the address ignored
    send(1, 1'b1, 16'h0004, 16'h1234, 16'h0000, 1'b0, 1'b1);
    send(1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b1);
    drain(1);

    // Stall window with req_valid held high
    @(posedge clk);
    #1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      int ph;
      @(negedge clk);
      ph = k % (WS0 + 2);
      check_val($sformatf("stall_k%0d", k), 32'(mem_stall[0]), 32'(ph <= WS0));
      check_val($sformatf("ready_k%0d", k), 32'(req_ready[0]), 32'(ph == 0));
      if (ph == 0) push_exp(0, 16'hBEEF, 1'b0, cyc + WS0 + 1);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    drain(0);

    // Reset on the edge that would commit a store
    send(0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, 1'b1);
    drain(0);
    send(0, 1'b1, 16'h0020, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset[0] = 1'b1;
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    @(negedge clk);
    check_val("midrst_ready", 32'(req_ready[0]), 1);
    check_val("midrst_valid", 32'(rsp_valid[0]), 0);
    repeat (5) @(negedge clk);
    send(0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1);
    drain(0);

    // Out-of-range store
    send(0, 1'b1, 16'h0000, 16'h0BAD, 16'h0000, 1'b0, 1'b1);
    send(0, 1'b1, 16'h0200, 16'h5555, 16'h0000, BOUNDS, 1'b1);
    send(0, 1'b0, 16'h0000, 16'h0000, BOUNDS ? 16'h0BAD : 16'h5555, 1'b0, 1'b1);
    drain(0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
